// File: rtl/decm.sv
// decm: RV32I decode stage with a two-entry (output + skid) elastic buffer on a valid/ready path.
// Optional CSR instruction decode is enabled by defining ECAP5_DPROC_ZICSR_EN.
module decm (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        output_valid_o,
    input  logic        output_ready_i,
    output logic [31:0] pc_o,
    output logic [3:0]  opclass_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [2:0]  func3_o,
    output logic [6:0]  func7_o,
    output logic [31:0] imm_o
);

    localparam logic [3:0] CLS_LUI     = 4'd0;
    localparam logic [3:0] CLS_AUIPC   = 4'd1;
    localparam logic [3:0] CLS_JAL     = 4'd2;
    localparam logic [3:0] CLS_JALR    = 4'd3;
    localparam logic [3:0] CLS_BRANCH  = 4'd4;
    localparam logic [3:0] CLS_LOAD    = 4'd5;
    localparam logic [3:0] CLS_STORE   = 4'd6;
    localparam logic [3:0] CLS_OP_IMM  = 4'd7;
    localparam logic [3:0] CLS_OP      = 4'd8;
    localparam logic [3:0] CLS_FENCE   = 4'd9;
    localparam logic [3:0] CLS_SYSTEM  = 4'd10;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
    localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [31:0]        pc;
        logic [3:0]         opclass;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         func3;
        logic [6:0]         func7;
        logic signed [31:0] imm;
    } entry_t;

    function automatic logic signed [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic signed [31:0] imm_s(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_u(input logic [31:0] w);
        return {w[31:12], 12'h000};
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    function automatic logic system_legal(input logic [31:0] w);
`ifdef ECAP5_DPROC_ZICSR_EN
        if (w[14:12] != 3'b000 && w[14:12] != 3'b100) begin
            return 1'b1;
        end
`endif
        return (w == WORD_ECALL) || (w == WORD_EBREAK);
    endfunction

    function automatic logic shift_imm_illegal(input logic [2:0] f3, input logic [6:0] f7);
        return (f3 == 3'b001 && f7 != 7'h00) ||
               (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
    endfunction

    function automatic logic op_legal(input logic [2:0] f3, input logic [6:0] f7);
        return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
    endfunction

    // Register fields pass through untouched; only opclass and imm depend on legality.
    function automatic entry_t decode(input logic [31:0] w, input logic [31:0] pc);
        entry_t e;
        e.pc      = pc;
        e.rd      = w[11:7];
        e.rs1     = w[19:15];
        e.rs2     = w[24:20];
        e.func3   = w[14:12];
        e.func7   = w[31:25];
        e.opclass = CLS_ILLEGAL;
        e.imm     = '0;
        if (w[1:0] == 2'b11) begin
            case (w[6:2])
                OPC_LUI: begin
                    e.opclass = CLS_LUI;
                    e.imm     = imm_u(w);
                end
                OPC_AUIPC: begin
                    e.opclass = CLS_AUIPC;
                    e.imm     = imm_u(w);
                end
                OPC_JAL: begin
                    e.opclass = CLS_JAL;
                    e.imm     = imm_j(w);
                end
                OPC_JALR: begin
                    if (w[14:12] == 3'b000) begin
                        e.opclass = CLS_JALR;
                        e.imm     = imm_i(w);
                    end
                end
                OPC_BRANCH: begin
                    e.opclass = CLS_BRANCH;
                    e.imm     = imm_b(w);
                end
                OPC_LOAD: begin
                    e.opclass = CLS_LOAD;
                    e.imm     = imm_i(w);
                end
                OPC_STORE: begin
                    e.opclass = CLS_STORE;
                    e.imm     = imm_s(w);
                end
                OPC_OP_IMM: begin
                    if (!shift_imm_illegal(w[14:12], w[31:25])) begin
                        e.opclass = CLS_OP_IMM;
                        e.imm     = imm_i(w);
                    end
                end
                OPC_OP: begin
                    if (op_legal(w[14:12], w[31:25])) begin
                        e.opclass = CLS_OP;
                    end
                end
                OPC_FENCE: begin
                    e.opclass = CLS_FENCE;
                end
                OPC_SYSTEM: begin
                    if (system_legal(w)) begin
                        e.opclass = CLS_SYSTEM;
                        e.imm     = {20'h00000, w[31:20]};
                    end
                end
                default: begin
                    e.opclass = CLS_ILLEGAL;
                end
            endcase
        end
        return e;
    endfunction

    entry_t dec_p0;
    entry_t out_p1;
    entry_t skid_p1;
    logic   out_vld_p1;
    logic   skid_vld_p1;
    logic   accept;
    logic   emit;

    assign dec_p0        = decode(instr_i, pc_i);
    assign input_ready_o = rst_i & ~skid_vld_p1;
    assign accept        = input_valid_i & input_ready_o;
    assign emit          = out_vld_p1 & output_ready_i;

    // ---- stage p0 -> p1: output register plus skid entry ----
    // A full skid implies input_ready_o was low, so no accept can coincide with a skid drain.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            out_vld_p1  <= 1'b0;
            skid_vld_p1 <= 1'b0;
            out_p1      <= '0;
            skid_p1     <= '0;
        end else if (flush_i) begin
            out_vld_p1  <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (!out_vld_p1 || emit) begin
            if (skid_vld_p1) begin
                out_p1      <= skid_p1;
                out_vld_p1  <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else begin
                out_vld_p1 <= accept;
                if (accept) begin
                    out_p1 <= dec_p0;
                end
            end
        end else if (accept) begin
            skid_p1     <= dec_p0;
            skid_vld_p1 <= 1'b1;
        end
    end

    assign output_valid_o = out_vld_p1;
    assign pc_o           = out_p1.pc;
    assign opclass_o      = out_p1.opclass;
    assign rd_o           = out_p1.rd;
    assign rs1_o          = out_p1.rs1;
    assign rs2_o          = out_p1.rs2;
    assign func3_o        = out_p1.func3;
    assign func7_o        = out_p1.func7;
    assign imm_o          = out_p1.imm;

endmodule

// File: tb/tb_decm.sv
// tb_decm: checks decm against a FIFO-of-decoded-words model every cycle, plus directed literal checks.
module tb_decm;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_o;
    logic [3:0]  opclass;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;

    int n_chk  = 0;
    int n_fail = 0;
    logic rand_rdy = 1'b0;
    logic [92:0] mq[$];

    always #5 clk = ~clk;

    decm dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .input_valid_i(in_valid), .input_ready_o(in_ready),
        .instr_i(instr), .pc_i(pc),
        .output_valid_o(out_valid), .output_ready_i(out_ready),
        .pc_o(pc_o), .opclass_o(opclass), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2),
        .func3_o(func3), .func7_o(func7), .imm_o(imm)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected decode built from the ISA's arithmetic meaning of each immediate.
    function automatic logic [92:0] model(input logic [31:0] w, input logic [31:0] a);
        int op, f3, f7, v;
        int c;
        logic [31:0] immv;
        int iv;
        op = int'(w[6:0]);
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        iv = (w[31] ? -2048 : 0) + int'(w[30:20]);
        c = 15;
        v = 0;
        case (op)
            'h37: begin c = 0; v = int'(w & 32'hFFFFF000); end
            'h17: begin c = 1; v = int'(w & 32'hFFFFF000); end
            'h6F: begin
                c = 2;
                v = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            end
            'h67: if (f3 == 0) begin c = 3; v = iv; end
            'h63: begin
                c = 4;
                v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            end
            'h03: begin c = 5; v = iv; end
            'h23: begin c = 6; v = (w[31] ? -2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:7]); end
            'h13: begin
                if ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32)) c = 15;
                else begin c = 7; v = iv; end
            end
            'h33: if (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))) c = 8;
            'h0F: c = 9;
            'h73: begin
                if (w == 32'h00000073 || w == 32'h00100073) begin c = 10; v = int'(w[31:20]); end
`ifdef ECAP5_DPROC_ZICSR_EN
                if (f3 != 0 && f3 != 4) begin c = 10; v = int'(w[31:20]); end
`endif
            end
            default: c = 15;
        endcase
        immv = v;
        return {a, 4'(c), w[11:7], w[19:15], w[24:20], w[14:12], w[31:25], immv};
    endfunction

    // Reference: a two-deep FIFO; ready means fewer than two held, valid means non-empty.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("ready", {95'b0, in_ready}, {95'b0, rst && (mq.size() < 2)});
            chk("valid", {95'b0, out_valid}, {95'b0, mq.size() > 0});
            if (mq.size() > 0)
                chk("data", {3'b0, pc_o, opclass, rd, rs1, rs2, func3, func7, imm}, {3'b0, mq[0]});
            if (!rst || flush) begin
                mq.delete();
            end else begin
                logic acc, emi;
                acc = in_valid && (mq.size() < 2);
                emi = (mq.size() > 0) && out_ready;
                if (emi) void'(mq.pop_front());
                if (acc) mq.push_back(model(instr, pc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] a);
        int tries;
        logic took;
        tries = 0;
        took = 1'b0;
        instr = w;
        pc = a;
        in_valid = 1'b1;
        while (!took && tries < 20) begin
            out_ready = (rand_rdy && tries < 6) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            took = in_ready;
            tries++;
            cyc();
        end
        chk("send_accepted", {95'b0, took}, 96'd1);
        in_valid = 1'b0;
    endtask

    logic [31:0] vec [0:18] = '{
        32'h123450B7, 32'hFFFFF117, 32'hFE000EE3, 32'hFE112E23, 32'hFFC0A183,
        32'h002081B3, 32'h4020D1B3, 32'h4010D093, 32'h40001093, 32'h00009067,
        32'h000080E7, 32'h00000073, 32'h00100073, 32'h30002173, 32'h30004073,
        32'h0FF0000F, 32'h00500091, 32'h0000007F, 32'h30200073
    };

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; pc = '0;
        repeat (3) cyc();
        chk("rst_ready", {95'b0, in_ready}, 96'd0);
        chk("rst_valid", {95'b0, out_valid}, 96'd0);

        // T1 / T2
        rst = 1'b1;
        in_valid = 1'b1; instr = 32'h00500093; pc = 32'h100;
        cyc();
        chk("t1_valid", {95'b0, out_valid}, 96'd1);
        chk("t1_class", {92'b0, opclass}, 96'd7);
        chk("t1_rd", {91'b0, rd}, 96'd1);
        chk("t1_rs1", {91'b0, rs1}, 96'd0);
        chk("t1_imm", {64'b0, imm}, 96'd5);
        chk("t1_pc", {64'b0, pc_o}, 96'h100);
        instr = 32'hFFDFF06F; pc = 32'h104;
        cyc();
        in_valid = 1'b0;
        chk("t2_class", {92'b0, opclass}, 96'd2);
        chk("t2_rd", {91'b0, rd}, 96'd0);
        chk("t2_imm", {64'b0, imm}, {64'b0, 32'hFFFFFFFC});
        cyc();

        // T3: back-pressure fills output then skid
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00A00113; pc = 32'h200;
        cyc();
        chk("t3_ready_after1", {95'b0, in_ready}, 96'd1);
        instr = 32'h402081B3; pc = 32'h204;
        cyc();
        chk("t3_ready_full", {95'b0, in_ready}, 96'd0);
        instr = 32'h0040A203; pc = 32'h208;
        cyc();
        chk("t3_hold_pc", {64'b0, pc_o}, 96'h200);
        out_ready = 1'b1;
        cyc();
        chk("t3_drain1_pc", {64'b0, pc_o}, 96'h204);
        chk("t3_release", {95'b0, in_ready}, 96'd1);
        cyc();
        in_valid = 1'b0;
        chk("t3_drain2_pc", {64'b0, pc_o}, 96'h208);
        cyc();

        // T4: flush while full, with a word offered
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00100093; pc = 32'h300;
        cyc();
        pc = 32'h304;
        cyc();
        flush = 1'b1; pc = 32'h308;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_valid", {95'b0, out_valid}, 96'd0);
        chk("t4_ready", {95'b0, in_ready}, 96'd1);
        out_ready = 1'b1;
        repeat (3) cyc();

        // T5 / T6
        in_valid = 1'b1; instr = 32'h300110F3; pc = 32'h400;
        cyc();
        chk("t5_rd", {91'b0, rd}, 96'd1);
        chk("t5_rs1", {91'b0, rs1}, 96'd2);
`ifdef ECAP5_DPROC_ZICSR_EN
        chk("t5_class", {92'b0, opclass}, 96'd10);
        chk("t5_imm", {64'b0, imm}, 96'h300);
`else
        chk("t5_class", {92'b0, opclass}, 96'd15);
        chk("t5_imm", {64'b0, imm}, 96'd0);
`endif
        instr = 32'h00000000; pc = 32'h404;
        cyc();
        chk("t6_zero_class", {92'b0, opclass}, 96'd15);
        chk("t6_zero_imm", {64'b0, imm}, 96'd0);
        instr = 32'h4000F033; pc = 32'h408;
        cyc();
        in_valid = 1'b0;
        chk("t6_op_class", {92'b0, opclass}, 96'd15);
        chk("t6_op_imm", {64'b0, imm}, 96'd0);
        cyc();

        // Opcode sweep under randomised back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 19; i++) send(vec[i], 32'h1000 + 32'(i) * 4);
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();

        // T6: reset while full
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00500093; pc = 32'h500;
        cyc();
        pc = 32'h504;
        cyc();
        chk("t6_full", {95'b0, in_ready}, 96'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        cyc();
        chk("t6_rst_ready", {95'b0, in_ready}, 96'd0);
        cyc();
        rst = 1'b1;
        out_ready = 1'b1;
        chk("t6_release_valid", {95'b0, out_valid}, 96'd0);
        cyc();
        chk("t6_after_valid", {95'b0, out_valid}, 96'd0);
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
